burst_arbiter: RTL and testbench



---
 rtl/burst_arbiter_pkg.sv | 19 +
 rtl/burst_arbiter_rr_select.sv | 29 ++
 rtl/burst_arbiter.sv | 137 +++++++++++++
 tb/tb_burst_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_arbiter_pkg.sv
// rtl/burst_arbiter_pkg.sv - shared types and helpers for burst_arbiter
package burst_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Burst counter must be able to hold the value max_burst itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // "last" resets to the top index so the first search starts at source 0.
  function automatic int last_reset(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/burst_arbiter_rr_select.sv
// rtl/burst_arbiter_rr_select.sv - rotating-priority encoder, search starts after pointer
module burst_arbiter_rr_select
  import burst_arbiter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan pointer+1, pointer+2, ... modulo WIDTH; first set request wins.
  always_comb begin : search
    int pos;
    pos   = 0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      pos = (int'(pointer) + k) % WIDTH;
      if (!valid && req[IDX_W'(pos)]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/burst_arbiter.sv
// rtl/burst_arbiter.sv - burst round-robin merge of source FIFOs; hold feature under BURST_ARBITER_HOLD_EN
module burst_arbiter
  import burst_arbiter_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST_N,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  input  logic                        READY_OUT,
  output logic [WIDTH-1:0]            READ_GRANT,
  output logic                        WRITE_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT,
  output logic                        BUSY
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(last_reset(WIDTH));
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel, sel_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [WIDTH-1:0] arb_req;
  logic [IDX_W-1:0] arb_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             hold_sel;
  logic             pop;

  logic [DATA_WIDTH-1:0] slice [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_slice
    assign slice[g] = DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef BURST_ARBITER_HOLD_EN
  // A requesting holder preempts round-robin: searching from the top index
  // makes the encoder return the lowest such holder.
  logic [WIDTH-1:0] hold_mask;
  assign hold_mask = WRITE_REQ & HOLD_REQ;
  assign arb_req   = (|hold_mask) ? hold_mask : WRITE_REQ;
  assign arb_ptr   = (|hold_mask) ? LAST_RST : last;
  assign hold_sel  = HOLD_REQ[sel];
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_REQ;
  assign arb_req     = WRITE_REQ;
  assign arb_ptr     = last;
  assign hold_sel    = 1'b0;
`endif

  burst_arbiter_rr_select #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req     (arb_req),
    .pointer (arb_ptr),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // Pop the granted source only while it has data and the sink accepts.
  always_comb begin
    READ_GRANT = '0;
    if ((state == GRANT) && BUS_RST_N) begin
      READ_GRANT[sel] = WRITE_REQ[sel] & READY_OUT;
    end
  end

  assign pop  = |READ_GRANT;
  assign BUSY = (state == GRANT);

  // Next-state: select in IDLE, count pops and decide burst end in GRANT.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (pop && (cnt != CNT_MAX)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        // Leaving on the limit uses the post-pop count so no extra pop follows.
        if (!hold_sel && ((cnt_nxt == CNT_MAX) || !WRITE_REQ[sel])) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
      sel   <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output word is captured on the same edge that pops the source.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      WRITE_OUT <= pop;
      if (pop) begin
        DATA_OUT <= slice[sel];
      end
    end
  end

endmodule

// File: tb/tb_burst_arbiter.sv
// tb/tb_burst_arbiter.sv - self-checking bench for burst_arbiter (either BURST_ARBITER_HOLD_EN setting)
module tb_burst_arbiter;

  localparam int WIDTH = 6;
  localparam int DW    = 32;
  localparam int MAXB  = 16;
`ifdef BURST_ARBITER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [WIDTH-1:0]      write_req;
  logic [WIDTH-1:0]      hold_req;
  logic [WIDTH*DW-1:0]   data_in;
  logic                  ready;
  logic [WIDTH-1:0]      read_grant;
  logic                  write_out;
  logic [DW-1:0]         data_out;
  logic                  busy;

  burst_arbiter #(.WIDTH(WIDTH), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .BUS_CLK    (clk),
    .BUS_RST_N  (rst_n),
    .WRITE_REQ  (write_req),
    .HOLD_REQ   (hold_req),
    .DATA_IN    (data_in),
    .READY_OUT  (ready),
    .READ_GRANT (read_grant),
    .WRITE_OUT  (write_out),
    .DATA_OUT   (data_out),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFOs and stimulus controls
  logic [DW-1:0]    src_q [WIDTH][$];
  logic [WIDTH-1:0] gap_m;
  logic [WIDTH-1:0] hold_v;
  bit               rdy;
  int               seqn = 0;
  int               pops0;

  // Reference model: who owns the port and how many words it has taken
  bit m_busy;
  int m_owner;
  int m_taken;
  int m_last;

  // Burst observations taken from the DUT outputs
  int obs_len[$];
  int obs_own[$];
  bit obs_prev_busy;

  typedef struct {
    int src;
    int words;
    bit toggle;
    int n;
    int l0;
    int l1;
    int l2;
  } row_t;
  row_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < WIDTH; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      src_q[s].push_back({s[3:0], 28'(seqn)});
      seqn++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < WIDTH; i++) begin
      write_req[i] = (src_q[i].size() > 0) && !gap_m[i];
      data_in[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    hold_req = hold_v;
    ready    = rdy;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_taken = 0;
    m_last  = WIDTH - 1;
    obs_len.delete();
    obs_own.delete();
    obs_prev_busy = 1'b0;
    pops0 = 0;
  endtask

  // Arbitration rules applied at a clock edge, from the inputs seen before it.
  task automatic model_update(input logic [WIDTH-1:0] wr, input logic [WIDTH-1:0] hd, input bit did_pop);
    int pick;
    bit held;
    if (m_busy) begin
      if (did_pop) m_taken++;
      held = HOLD_EN && hd[m_owner];
      if (!held && (m_taken >= MAXB || !wr[m_owner])) m_busy = 1'b0;
    end else begin
      pick = -1;
      if (HOLD_EN) begin
        for (int i = 0; i < WIDTH; i++) if (pick < 0 && wr[i] && hd[i]) pick = i;
      end
      for (int k = 1; k <= WIDTH; k++) begin
        if (pick < 0 && wr[(m_last + k) % WIDTH]) pick = (m_last + k) % WIDTH;
      end
      if (pick >= 0) begin
        m_busy  = 1'b1;
        m_owner = pick;
        m_last  = pick;
        m_taken = 0;
      end
    end
  endtask

  // One clock: drive, compare combinational grant, step edge, compare registered outputs.
  task automatic cycle();
    logic [WIDTH-1:0] eg;
    logic [WIDTH-1:0] wr_s;
    logic [WIDTH-1:0] hd_s;
    logic [DW-1:0]    ew;
    int               popped;
    drive();
    #1;
    eg = '0;
    if (m_busy && write_req[m_owner] && ready) eg[m_owner] = 1'b1;
    check("read_grant", read_grant, eg);
    check("busy", busy, m_busy);
    if (busy && !obs_prev_busy) begin
      obs_len.push_back(0);
      obs_own.push_back(-1);
    end
    obs_prev_busy = busy;
    if (busy && (|read_grant) && obs_len.size() > 0) begin
      obs_len[obs_len.size()-1] = obs_len[obs_len.size()-1] + 1;
      if (obs_own[obs_own.size()-1] < 0) begin
        for (int i = 0; i < WIDTH; i++) if (read_grant[i]) obs_own[obs_own.size()-1] = i;
      end
    end
    popped = -1;
    ew = '0;
    if (|eg) begin
      popped = m_owner;
      ew = src_q[m_owner][0];
    end
    wr_s = write_req;
    hd_s = hold_req;
    @(posedge clk);
    #1;
    model_update(wr_s, hd_s, popped >= 0);
    if (popped >= 0) begin
      void'(src_q[popped].pop_front());
      if (popped == 0) pops0++;
    end
    check("write_out", write_out, popped >= 0);
    if (popped >= 0) check("data_out", data_out, ew);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < WIDTH; i++) src_q[i].delete();
    gap_m  = '0;
    hold_v = '0;
    rdy    = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_drain(input bit toggle, input int budget);
    int n = 0;
    while ((any_pending() || m_busy) && n < budget) begin
      rdy = toggle ? (n % 2 == 0) : 1'b1;
      cycle();
      n++;
    end
    check("drain_done", any_pending() || m_busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    int exp_l[3];

    tbl[0] = '{2, 40, 1'b0, 3, 16, 16, 8};
    tbl[1] = '{5, 16, 1'b0, 1, 16, 0, 0};
    tbl[2] = '{0, 17, 1'b0, 2, 16, 1, 0};
    tbl[3] = '{3, 20, 1'b1, 2, 16, 4, 0};

    // Reset state with a source requesting: nothing may move.
    rst_n  = 1'b0;
    gap_m  = '0;
    hold_v = '1;
    rdy    = 1'b1;
    load(0, 2);
    drive();
    #12;
    check("rst_read_grant", read_grant, 0);
    check("rst_write_out", write_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);

    // Single-source vector table
    for (int r = 0; r < 4; r++) begin
      do_reset();
      load(tbl[r].src, tbl[r].words);
      run_drain(tbl[r].toggle, 400);
      exp_l = '{tbl[r].l0, tbl[r].l1, tbl[r].l2};
      check($sformatf("row%0d_nbursts", r), obs_len.size(), tbl[r].n);
      for (int b = 0; b < tbl[r].n; b++) begin
        if (b < obs_len.size()) begin
          check($sformatf("row%0d_len%0d", r, b), obs_len[b], exp_l[b]);
          check($sformatf("row%0d_own%0d", r, b), obs_own[b], tbl[r].src);
        end
      end
    end

    // All six sources busy: strict rotation, full bursts
    do_reset();
    for (int i = 0; i < WIDTH; i++) load(i, 40);
    run_drain(1'b0, 600);
    for (int b = 0; b < 7; b++) begin
      if (b < obs_len.size()) begin
        check($sformatf("all_own%0d", b), obs_own[b], b % WIDTH);
        check($sformatf("all_len%0d", b), obs_len[b], MAXB);
      end
    end

    // TLU record of 20 words with hold, empty gap after word 17
    do_reset();
    load(0, 20);
    for (int i = 1; i < WIDTH; i++) load(i, 20);
    g = 0;
    n = 0;
    while ((any_pending() || m_busy) && n < 600) begin
      hold_v[0] = src_q[0].size() > 0;
      gap_m[0]  = (pops0 == 17) && (g < 2);
      if (gap_m[0]) g++;
      cycle();
      n++;
    end
    check("hold_drain_done", any_pending() || m_busy, 0);
    check("hold_own0", obs_own[0], 0);
    check("hold_len0", obs_len[0], HOLD_EN ? 20 : 16);
    check("hold_own1", obs_own[1], 1);

    // Reset while the 7th pop of a burst is being granted
    do_reset();
    load(1, 30);
    n = 0;
    while (!(obs_len.size() > 0 && obs_len[0] == 6) && n < 40) begin
      cycle();
      n++;
    end
    drive();
    #1;
    check("prereset_grant", read_grant, 6'b000010);
    rst_n = 1'b0;
    #1;
    check("midrst_read_grant", read_grant, 0);
    check("midrst_write_out", write_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check("midrst_src1_left", src_q[1].size(), 24);
    load(0, 3);
    run_drain(1'b0, 200);
    check("postrst_first_own", obs_own[0], 0);

    // Source 3 runs dry after 5 words; source 4 is next
    do_reset();
    load(2, 1);
    load(3, 5);
    load(4, 5);
    run_drain(1'b0, 100);
    check("empty_n", obs_len.size(), 3);
    check("empty_own0", obs_own[0], 2);
    check("empty_own1", obs_own[1], 3);
    check("empty_len1", obs_len[1], 5);
    check("empty_own2", obs_own[2], 4);
    check("empty_len2", obs_len[2], 5);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) load(i, $urandom_range(1, 20));
        gap_m[i]  = ($urandom_range(0, 7) == 0);
        hold_v[i] = ($urandom_range(0, 15) == 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    gap_m  = '0;
    hold_v = '0;
    run_drain(1'b0, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
